// File: rtl/usb_bridge_pkg.sv
// rtl/usb_bridge_pkg.sv - shared types and helpers for the usb_cdc stream bridge
package usb_bridge_pkg;

  typedef logic [7:0] byte_t;

  // Width of a byte-count field able to hold 0..pack_bytes
  function automatic int cnt_w(input int pack_bytes);
    return $clog2(pack_bytes + 1);
  endfunction

  // A requested count of 0 or above the word size means "whole word"
  function automatic int unsigned clamp_bytes(input int unsigned n, input int unsigned pack_bytes);
    return ((n == 0) || (n > pack_bytes)) ? pack_bytes : n;
  endfunction

endpackage

// File: rtl/usb_bridge_fifo.sv
// rtl/usb_bridge_fifo.sv - word FIFO with registered head output; level port under USB_BRIDGE_LEVEL_EN
module usb_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef USB_BRIDGE_LEVEL_EN
  output logic [PW-1:0]    o_level,
`endif
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic [PW-1:0]    w_used;
  logic [PW-1:0]    w_rd_next;
  logic [PW-1:0]    w_avail;
  logic             w_push;
  logic             w_pop;

  // The head entry shown on o_data is still counted in w_used until popped
  assign w_used    = r_wr_ptr - r_rd_ptr;
  assign o_full    = (w_used == PW'(DEPTH));
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && r_valid;
  assign w_rd_next = r_rd_ptr + PW'(w_pop);
  // Entries already in storage before this edge's push, after this edge's pop
  assign w_avail   = r_wr_ptr - w_rd_next;

  assign o_data  = r_data;
  assign o_valid = r_valid;
`ifdef USB_BRIDGE_LEVEL_EN
  assign o_level = w_used;
`endif

  // Storage array write
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[IW-1:0]] <= i_push_data;
    end
  end

  // Read/write pointers with wrap bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_next;
    end
  end

  // Registered head output, zero while empty
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= (w_avail != '0);
      r_data  <= (w_avail != '0) ? r_mem[w_rd_next[IW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/usb_cdc_stream_bridge.sv
// rtl/usb_cdc_stream_bridge.sv - usb_cdc byte streams to wide app words; USB_BRIDGE_LEVEL_EN adds FIFO level ports
module usb_cdc_stream_bridge
  import usb_bridge_pkg::*;
#(
  parameter int PACK_BYTES = 4,
  parameter int RX_DEPTH   = 4,
  parameter int TX_DEPTH   = 4,
  parameter int TIMEOUT    = 16,
  localparam int AW = 8 * PACK_BYTES,
  localparam int CW = cnt_w(PACK_BYTES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
`ifdef USB_BRIDGE_LEVEL_EN
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_level_o,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level_o,
`endif
  input  logic [7:0]                    usb_out_data_i,
  input  logic                          usb_out_valid_i,
  output logic                          usb_out_ready_o,
  output logic [7:0]                    usb_in_data_o,
  output logic                          usb_in_valid_o,
  input  logic                          usb_in_ready_i,
  output logic [AW-1:0]                 app_rx_data_o,
  output logic [CW-1:0]                 app_rx_bytes_o,
  output logic                          app_rx_valid_o,
  input  logic                          app_rx_ready_i,
  input  logic [AW-1:0]                 app_tx_data_i,
  input  logic [CW-1:0]                 app_tx_bytes_i,
  input  logic                          app_tx_valid_i,
  output logic                          app_tx_ready_o
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FW = AW + CW;
  localparam logic [CW-1:0] FULL_CNT = CW'(PACK_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(PACK_BYTES - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

  // ---------------- RX: bytes -> words ----------------
  logic [AW-1:0] r_rx_word;
  logic [CW-1:0] r_rx_cnt;
  logic [TW-1:0] r_to_cnt;

  byte_t         w_rx_byte;
  logic          w_rx_full;
  logic          w_rx_accept;
  logic          w_rx_complete;
  logic          w_flush;
  logic          w_rx_push;
  logic [AW-1:0] w_rx_merged;
  logic [FW-1:0] w_rx_push_data;
  logic [FW-1:0] w_rx_q;
  logic          w_rx_q_valid;

  assign w_rx_byte       = usb_out_data_i;
  assign usb_out_ready_o = !rst_i && !w_rx_full;
  assign w_rx_accept     = usb_out_valid_i && usb_out_ready_o;
  assign w_rx_merged     = r_rx_word | (AW'(w_rx_byte) << {r_rx_cnt, 3'b000});
  assign w_rx_complete   = w_rx_accept && (r_rx_cnt == LAST_IDX);
  // An incoming byte always beats an expiring timeout
  assign w_flush         = (TIMEOUT != 0) && (r_rx_cnt != '0) && (r_to_cnt == TO_LIMIT)
                           && !w_rx_full && !w_rx_accept;
  assign w_rx_push       = w_rx_complete || w_flush;
  assign w_rx_push_data  = w_rx_complete ? {FULL_CNT, w_rx_merged} : {r_rx_cnt, r_rx_word};

  // Packer: accumulate bytes little-endian, clear on push
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_word <= '0;
      r_rx_cnt  <= '0;
    end else if (w_rx_push) begin
      r_rx_word <= '0;
      r_rx_cnt  <= '0;
    end else if (w_rx_accept) begin
      r_rx_word <= w_rx_merged;
      r_rx_cnt  <= r_rx_cnt + CW'(1);
    end
  end

  // Idle counter: restarts on each byte, saturates at the limit while a partial word waits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (w_rx_accept || w_flush) begin
      r_to_cnt <= '0;
    end else if ((r_rx_cnt != '0) && (r_to_cnt != TO_LIMIT)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  usb_bridge_fifo #(
    .WIDTH (FW),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
`ifdef USB_BRIDGE_LEVEL_EN
    .o_level     (rx_level_o),
`endif
    .i_push      (w_rx_push),
    .i_push_data (w_rx_push_data),
    .o_full      (w_rx_full),
    .i_pop       (app_rx_ready_i),
    .o_data      (w_rx_q),
    .o_valid     (w_rx_q_valid)
  );

  assign app_rx_data_o  = w_rx_q[AW-1:0];
  assign app_rx_bytes_o = w_rx_q[FW-1:AW];
  assign app_rx_valid_o = w_rx_q_valid;

  // ---------------- TX: words -> bytes ----------------
  logic [AW-1:0] r_tx_word;
  logic [CW-1:0] r_tx_left;

  logic          w_tx_full;
  logic          w_tx_push;
  logic [FW-1:0] w_tx_push_data;
  logic [FW-1:0] w_tx_q;
  logic          w_tx_q_valid;
  logic          w_tx_xfer;
  logic          w_tx_last;
  logic          w_tx_load;

  assign app_tx_ready_o = !rst_i && !w_tx_full;
  assign w_tx_push      = app_tx_valid_i && app_tx_ready_o;
  assign w_tx_push_data = {CW'(clamp_bytes(32'(app_tx_bytes_i), 32'(PACK_BYTES))), app_tx_data_i};

  usb_bridge_fifo #(
    .WIDTH (FW),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
`ifdef USB_BRIDGE_LEVEL_EN
    .o_level     (tx_level_o),
`endif
    .i_push      (w_tx_push),
    .i_push_data (w_tx_push_data),
    .o_full      (w_tx_full),
    .i_pop       (w_tx_load),
    .o_data      (w_tx_q),
    .o_valid     (w_tx_q_valid)
  );

  assign usb_in_valid_o = (r_tx_left != '0);
  assign usb_in_data_o  = r_tx_word[7:0];
  assign w_tx_xfer      = usb_in_valid_o && usb_in_ready_i;
  assign w_tx_last      = w_tx_xfer && (r_tx_left == CW'(1));
  // Reload on the last byte's transfer so consecutive words stream without a bubble
  assign w_tx_load      = w_tx_q_valid && (!usb_in_valid_o || w_tx_last);

  // Unpacker: shift out LSB first, count down remaining bytes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_word <= '0;
      r_tx_left <= '0;
    end else if (w_tx_load) begin
      r_tx_word <= w_tx_q[AW-1:0];
      r_tx_left <= w_tx_q[FW-1:AW];
    end else if (w_tx_last) begin
      r_tx_word <= '0;
      r_tx_left <= '0;
    end else if (w_tx_xfer) begin
      r_tx_word <= r_tx_word >> 8;
      r_tx_left <= r_tx_left - CW'(1);
    end
  end

endmodule
